// File: rtl/ahb_lite_master.sv
// ============================================================================
// Module   : ahb_lite_master
// Brief    : Single-outstanding AHB-Lite initiator driven by a valid/ready
//            command port. Optional timeout abort: define AHBM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [31:0]       HRDATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                sticky_q, sticky_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                w_misaligned;
  logic                w_timeout;
  logic                w_unused;

  assign w_unused = HRESP[1];

`ifdef AHBM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;

  // Counts consecutive HREADY-low cycles; any ready cycle or state change clears it.
  always_comb begin
    to_cnt_d  = '0;
    w_timeout = 1'b0;
    w_cnt_inc = to_cnt_q + CNT_W'(1);
    if ((state_q == S_ADDR || state_q == S_DATA) && !HREADY) begin
      if (w_cnt_inc == TO_LIMIT) begin
        w_timeout = 1'b1;
      end else begin
        to_cnt_d = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_misaligned = (cmd_size > 3'd2)
                      || (cmd_size == 3'd1 && cmd_addr[0])
                      || (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    sticky_d    = sticky_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready   = 1'b0;
    HTRANS      = HTRANS_IDLE;

    case (state_q)
      S_IDLE: begin
        cmd_ready = HRESETn;
        if (cmd_valid) begin
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          size_d   = cmd_size;
          wdata_d  = cmd_wdata;
          sticky_d = 1'b0;
          if (w_misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        if (w_timeout) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (HREADY) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (HREADY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sticky_q | HRESP[0];
          rsp_rdata_d = write_q ? 32'h0 : HRDATA;
        end else if (HRESP[0]) begin
          // First cycle of the two-cycle ERROR response.
          sticky_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= 3'd0;
      wdata_q     <= 32'h0;
      sticky_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      sticky_q    <= sticky_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = addr_q;
  assign HSIZE     = size_q;
  assign HWRITE    = write_q;
  assign HWDATA    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
// ============================================================================
// Module   : tb_ahb_lite_master
// Brief    : Directed self-checking bench for ahb_lite_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_master;

`ifdef AHBM_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  ahb_lite_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h exp 0", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr got %h exp 0", HADDR); end
    checks++; if (HSIZE !== 3'd0 || HWRITE !== 1'b0) begin errors++; $display("FAIL rst_hsize_hwrite got %h/%b exp 0/0", HSIZE, HWRITE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h exp 0", HWDATA); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp got v%b e%b d%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    HRESETn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    HREADY = 1'b1;
    issue(1'b1, 32'h4, 3'd2, 32'h5);
    tick();
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL wr_addr_htrans got %h exp 2", HTRANS); end
    checks++; if (HADDR !== 32'h4 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin errors++; $display("FAIL wr_addr_ctrl got %h/%b/%h exp 4/1/2", HADDR, HWRITE, HSIZE); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_addr_ready got %b exp 0", cmd_ready); end
    tick();
    checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h5) begin errors++; $display("FAIL wr_data_phase got %h/%h exp 0/5", HTRANS, HWDATA); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_early_rsp got %b exp 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp got v%b e%b d%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_rsp_ready got %b exp 1", cmd_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    HREADY = 1'b1;
    issue(1'b0, 32'h8, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8 || HWRITE !== 1'b0) begin errors++; $display("FAIL rd_addr got %h/%h/%b exp 2/8/0", HTRANS, HADDR, HWRITE); end
    tick();
    HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait%0d got htrans %h v%b exp 0/0", i, HTRANS, rsp_valid); end
      tick();
    end
    checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_last got htrans %h v%b exp 0/0", HTRANS, rsp_valid); end
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    tick();
    HRDATA = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got v%b d%h e%b exp 1/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rsp_hold got v%b d%h exp 0/12345678", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_addr_wait();
    HREADY = 1'b0;
    issue(1'b1, 32'h10, 3'd1, 32'h0000_ABCD);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HSIZE !== 3'd1 || HWRITE !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL aw_stable%0d got %h/%h/%h/%b rdy%b exp 2/10/1/1 rdy0", i, HTRANS, HADDR, HSIZE, HWRITE, cmd_ready);
      end
      if (i == 3) HREADY = 1'b1;
      tick();
    end
    checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h0000_ABCD) begin errors++; $display("FAIL aw_data got %h/%h exp 0/0000abcd", HTRANS, HWDATA); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL aw_rsp got v%b e%b exp 1/0", rsp_valid, rsp_err); end
    tick();
  endtask

  task automatic test_error();
    HREADY = 1'b1;
    issue(1'b0, 32'hC, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0; HRESP = 2'b01; HRDATA = 32'h0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL err_first got v%b htrans %h exp 0/0", rsp_valid, HTRANS); end
    HREADY = 1'b1; HRESP = 2'b01;
    tick();
    HRESP = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rsp got v%b e%b d%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", rsp_err); end
    // Error flagged only in the first response cycle must still be reported.
    issue(1'b1, 32'h14, 3'd2, 32'h77);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0; HRESP = 2'b01;
    tick();
    HREADY = 1'b1; HRESP = 2'b00;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_sticky got v%b e%b d%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    issue(1'b0, 32'h0, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HRDATA = 32'hCAFE_0001;
    tick();
    HRDATA = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL err_recover got v%b e%b d%h exp 1/0/cafe0001", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3] = '{32'h2, 32'h0, 32'h1};
    logic [2:0]  sizes [3] = '{3'd2, 3'd3, 3'd1};
    HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, addrs[i], sizes[i], 32'h0);
      tick();
      cmd_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL mis%0d_rsp got v%b e%b d%h exp 1/1/0", i, rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mis%0d_bus got htrans %h rdy%b exp 0/1", i, HTRANS, cmd_ready); end
      tick();
      checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mis%0d_after got htrans %h v%b exp 0/0", i, HTRANS, rsp_valid); end
    end
    issue(1'b0, 32'h3, 3'd0, 32'h0);
    tick();
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL byte_odd got htrans %h v%b exp 2/0", HTRANS, rsp_valid); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL byte_odd_rsp got v%b e%b exp 1/0", rsp_valid, rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    HREADY = 1'b1;
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    tick();
    HRESETn = 1'b0;
    tick();
    checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got htrans %h v%b rdy%b exp 0/0/0", HTRANS, rsp_valid, cmd_ready); end
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL rmid_release got rdy%b v%b htrans %h exp 1/0/0", cmd_ready, rsp_valid, HTRANS); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rmid_rsp_clear got d%h e%b exp 0/0", rsp_rdata, rsp_err); end
  endtask

`ifdef AHBM_TIMEOUT_EN
  task automatic test_timeout();
    HREADY = 1'b0;
    issue(1'b0, 32'h30, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early%0d got v%b exp 0", i, rsp_valid); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || HTRANS !== 2'b00) begin errors++; $display("FAIL to_abort got v%b e%b d%h htrans %h exp 1/1/0/0", rsp_valid, rsp_err, rsp_rdata, HTRANS); end
    HREADY = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = 32'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_addr_wait();
    test_error();
    test_misaligned();
    test_reset_mid();
`ifdef AHBM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
